// File: rtl/score_keeper_pkg.sv
// Shared definitions for the score keeper: FSM state encodings, BCD limits
// and the seven-segment glyph table (active-high, bit order gfedcba).
// Imported by score_keeper and seven_seg_encoder.
package score_keeper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INC     = 3'd1,
    ST_COMPARE = 3'd2,
    ST_ENCODE  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Display byte layout: bit7 unused (0), bits6:0 = gfedcba.
  function automatic logic [7:0] seg_to_byte(input logic [6:0] seg);
    return {1'b0, seg};
  endfunction

endpackage

// File: rtl/score_keeper_seven_seg_encoder.sv
// Seven-segment encoder: one BCD digit to an active-high gfedcba pattern.
// Purely combinational, zero latency, no handshake.
// Ports: bcd (4-bit digit in), seg (7-bit segment pattern out).
module seven_seg_encoder
  import score_keeper_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      // Codes 10..15 only appear if the digit store is corrupted.
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// BCD score counter with retained high score, driving seven-segment bytes.
// Latency: start (enable rising edge) to ready=1 within 2*SCORE_DIGITS+2 cycles.
// Handshake: ready drops on a start; the requester holds enable until ready
// returns, then drops it. Ports: clock, reset_n, enable, clear -> ready,
// display, highDisplay, overflow.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int SCORE_DIGITS = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      clear,
  output logic                      ready,
  output logic [SCORE_DIGITS*8-1:0] display,
  output logic [SCORE_DIGITS*8-1:0] highDisplay,
  output logic                      overflow
);

  localparam int IDX_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCORE_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [SCORE_DIGITS*8-1:0] DISP_ZERO = {SCORE_DIGITS{1'b0, SEG_0}};

  state_t                         state;
  logic [SCORE_DIGITS-1:0][3:0]   score;
  logic [SCORE_DIGITS-1:0][3:0]   high;
  logic [IDX_W-1:0]               idx;
  logic                           enable_prev;
  logic                           clear_pending;
  logic                           start;
  logic [SCORE_DIGITS-1:0][6:0]   seg_score;
  logic [SCORE_DIGITS-1:0][6:0]   seg_high;

  assign start = enable && !enable_prev;

  for (genvar k = 0; k < SCORE_DIGITS; k++) begin : g_enc
    seven_seg_encoder u_enc_score (.bcd(score[k]), .seg(seg_score[k]));
    seven_seg_encoder u_enc_high  (.bcd(high[k]),  .seg(seg_high[k]));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      score         <= '0;
      high          <= '0;
      idx           <= '0;
      enable_prev   <= 1'b0;
      clear_pending <= 1'b0;
      overflow      <= 1'b0;
      ready         <= 1'b1;
      display       <= DISP_ZERO;
      highDisplay   <= DISP_ZERO;
    end else begin
      enable_prev <= enable;

      case (state)
        ST_IDLE: begin
          ready <= 1'b1;
          if (start) begin
            // A clear coinciding with a start is deferred until after it.
            if (clear) clear_pending <= 1'b1;
            ready <= 1'b0;
            idx   <= '0;
            state <= ST_INC;
          end else if (clear) begin
            score         <= '0;
            overflow      <= 1'b0;
            clear_pending <= 1'b0;
            state         <= ST_ENCODE;
          end
        end

        // Ripple the carry one digit per cycle, LSD first.
        ST_INC: begin
          if (clear) clear_pending <= 1'b1;
          if (score[idx] < BCD_NINE) begin
            score[idx] <= score[idx] + 4'd1;
            idx        <= LAST_IDX;
            state      <= ST_COMPARE;
          end else if (idx != LAST_IDX) begin
            score[idx] <= '0;
            idx        <= idx + IDX_ONE;
          end else begin
            // Carry out of the MSD: saturate at all nines.
            score    <= {SCORE_DIGITS{BCD_NINE}};
            overflow <= 1'b1;
            idx      <= LAST_IDX;
            state    <= ST_COMPARE;
          end
        end

        // MSD-first magnitude compare; first differing digit decides.
        ST_COMPARE: begin
          if (clear) clear_pending <= 1'b1;
          if (score[idx] > high[idx]) begin
            high  <= score;
            state <= ST_ENCODE;
          end else if (score[idx] < high[idx]) begin
            state <= ST_ENCODE;
          end else if (idx == '0) begin
            state <= ST_ENCODE;
          end else begin
            idx <= idx - IDX_ONE;
          end
        end

        ST_ENCODE: begin
          if (clear) clear_pending <= 1'b1;
          for (int k = 0; k < SCORE_DIGITS; k++) begin
            display[k*8 +: 8]     <= seg_to_byte(seg_score[k]);
            highDisplay[k*8 +: 8] <= seg_to_byte(seg_high[k]);
          end
          ready <= 1'b1;
          state <= ST_DONE;
        end

        ST_DONE: begin
          ready <= 1'b1;
          if (!enable) begin
            if (clear_pending || clear) begin
              // Deferred clear: re-encode before signalling ready again.
              score         <= '0;
              overflow      <= 1'b0;
              clear_pending <= 1'b0;
              ready         <= 1'b0;
              state         <= ST_ENCODE;
            end else begin
              state <= ST_IDLE;
            end
          end else if (clear) begin
            clear_pending <= 1'b1;
          end
        end

        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper (SCORE_DIGITS=3): stimulus pushes the
// expected display/highDisplay/overflow; a monitor pops and compares on each
// rising edge of ready, or when the stimulus requests a check (clear in IDLE).
module tb_score_keeper;

  typedef struct packed {
    logic [23:0] d;
    logic [23:0] h;
    logic        o;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic        ready;
  logic [23:0] display;
  logic [23:0] highDisplay;
  logic        overflow;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   req_cnt  = 0;
  int   seen_cnt = 0;
  logic ready_q  = 1'b1;
  int   m_score  = 0;
  int   m_high   = 0;

  score_keeper #(.SCORE_DIGITS(3)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .ready       (ready),
    .display     (display),
    .highDisplay (highDisplay),
    .overflow    (overflow)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endfunction

  function automatic logic [23:0] enc(input int v);
    logic [7:0] t [10];
    t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    return {t[(v / 100) % 10], t[(v / 10) % 10], t[v % 10]};
  endfunction

  // Monitor: compare whenever the DUT signals completion.
  always @(negedge clock) begin
    if (reset_n && ((ready && !ready_q) || (req_cnt != seen_cnt))) begin
      if (req_cnt != seen_cnt) seen_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("display", display, e.d);
        check("highDisplay", highDisplay, e.h);
        check("overflow", overflow, e.o);
      end
    end
    ready_q = ready;
  end

  task automatic push(input logic [23:0] d, input logic [23:0] h, input logic o);
    exp_t x;
    x.d = d; x.h = h; x.o = o;
    exp_q.push_back(x);
  endtask

  // One enable request; hold = total cycles enable stays high (min: until ready).
  task automatic run_pulse(input int hold);
    int  cnt;
    bit  got;
    cnt = 0; got = 0;
    @(negedge clock) enable = 1'b1;
    while (cnt < 40 && !got) begin
      @(posedge clock); #1;
      cnt++;
      if (ready) got = 1;
    end
    check("start_to_ready_within_8", (got && cnt <= 8), 64'd1);
    if (hold > cnt) repeat (hold - cnt) @(posedge clock);
    @(negedge clock) enable = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic bump_model();
    if (m_score < 999) m_score++;
    if (m_score > m_high) m_high = m_score;
  endtask

  // Expected values from the bench's decimal model.
  task automatic inc_to(input int target);
    while (m_score < target) begin
      bump_model();
      push(enc(m_score), enc(m_high), 1'b0);
      run_pulse(0);
    end
  endtask

  // Expected values written out by hand.
  task automatic hand_pulse(input int hold, input logic [23:0] d, input logic [23:0] h, input logic o);
    bump_model();
    push(d, h, o);
    run_pulse(hold);
  endtask

  task automatic request_check(input logic [23:0] d, input logic [23:0] h, input logic o);
    @(posedge clock); #1;
    push(d, h, o);
    req_cnt++;
    @(negedge clock);
  endtask

  task automatic idle_clear(input logic [23:0] d, input logic [23:0] h);
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    repeat (3) @(negedge clock);
    m_score = 0;
    request_check(d, h, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock) reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    m_score = 0; m_high = 0;
    request_check(24'h3F3F3F, 24'h3F3F3F, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    // 1: reset state
    check("ready_after_reset", ready, 64'd1);
    request_check(24'h3F3F3F, 24'h3F3F3F, 1'b0);

    // 2: single long enable
    hand_pulse(25, 24'h3F3F06, 24'h3F3F06, 1'b0);

    // 3: up to 10, then 99 -> 100
    inc_to(9);
    hand_pulse(0, 24'h3F063F, 24'h3F063F, 1'b0);
    inc_to(99);
    hand_pulse(0, 24'h063F3F, 24'h063F3F, 1'b0);

    // 4: saturate at 999, then clear
    inc_to(999);
    hand_pulse(0, 24'h6F6F6F, 24'h6F6F6F, 1'b1);
    idle_clear(24'h3F3F3F, 24'h6F6F6F);

    // 5: fresh reset, score 5, clear, score 3
    do_reset();
    inc_to(4);
    hand_pulse(0, 24'h3F3F6D, 24'h3F3F6D, 1'b0);
    idle_clear(24'h3F3F3F, 24'h3F3F6D);
    inc_to(2);
    hand_pulse(0, 24'h3F3F4F, 24'h3F3F6D, 1'b0);

    // 6: enable held 200 cycles with a clear mid-operation
    push(24'h3F3F66, 24'h3F3F6D, 1'b0);
    push(24'h3F3F3F, 24'h3F3F6D, 1'b0);
    @(negedge clock) enable = 1'b1;
    @(negedge clock);
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    repeat (197) @(negedge clock);
    enable = 1'b0;
    repeat (6) @(negedge clock);
    check("ready_after_deferred_clear", ready, 64'd1);
    m_score = 0;

    // 6: reset in the middle of an increment
    hand_pulse(0, 24'h3F3F06, 24'h3F3F6D, 1'b0);
    @(negedge clock) enable = 1'b1;
    @(posedge clock); #1;
    check("ready_low_in_inc", ready, 64'd0);
    reset_n = 1'b0;
    #1;
    check("mid_reset_ready", ready, 64'd1);
    check("mid_reset_display", display, 24'h3F3F3F);
    check("mid_reset_highDisplay", highDisplay, 24'h3F3F3F);
    check("mid_reset_overflow", overflow, 64'd0);
    @(negedge clock) enable = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    repeat (10) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
